// File: rtl/hs_bus_amba_axi_burst_addr_gen.sv
// AXI burst type encodings and bus-width helpers shared by AXI subordinate logic.
package hs_bus_amba_axi_typedefs_pkg;

  typedef enum logic [1:0] {
    AxBURST_FIXED    = 2'b00,
    AxBURST_INCR     = 2'b01,
    AxBURST_WRAP     = 2'b10,
    AxBURST_RESERVED = 2'b11
  } axburst_e;

  // AxSIZE encoding (log2 bytes per beat) of a full-width beat on a bus of data_width bits.
  function automatic logic [2:0] get_axsize(input int unsigned data_width);
    logic [2:0] s;
    s = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_width) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// hs_bus_amba_axi_burst_addr_gen
// Expands one AXI AW/AR command into per-beat byte addresses with beat index,
// last flag and a burst-wide legality flag.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_valid_i/ready_o command handshake; cmd_addr_i/len_i/size_i/burst_i = AxADDR/AxLEN/AxSIZE/AxBURST
//   beat_valid_o/ready_i beat handshake
//   beat_addr_o         byte address of the current beat
//   beat_idx_o          beat number 0..len
//   beat_last_o         final beat of the burst
//   beat_err_o          burst flagged illegal (addresses then held as FIXED)
//   busy_o              burst in progress
module hs_bus_amba_axi_burst_addr_gen
  import hs_bus_amba_axi_typedefs_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [2:0]            cmd_size_i,
  input  axburst_e              cmd_burst_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [7:0]            beat_idx_o,
  output logic                  beat_last_o,
  output logic                  beat_err_o,
  output logic                  busy_o
);

  localparam logic [2:0] MAX_SIZE = get_axsize(DATA_WIDTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  axburst_e              burst_q;
  logic [ADDR_WIDTH-1:0] wrap_lo_q;
  logic [ADDR_WIDTH-1:0] wrap_hi_q;

  logic [ADDR_WIDTH-1:0] size_mask;
  logic [16:0]           wrap_bytes_full;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] wrap_lo;
  logic [11:0]           aligned_lo;
  logic [16:0]           cross_sum;
  logic                  len_ok;
  logic                  cmd_err;
  logic                  beat_hs;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] wrap_nxt;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Command decode: wrap window and legality, evaluated on the live command inputs.
  // (len+1)<<size peaks at 256*128 = 32768, so 17 bits hold both it and the 4 KB sum.
  always_comb begin
    size_mask       = (ADDR_WIDTH'(1) << cmd_size_i) - ADDR_WIDTH'(1);
    wrap_bytes_full = 17'({1'b0, cmd_len_i} + 9'd1) << cmd_size_i;
    wrap_bytes      = ADDR_WIDTH'(wrap_bytes_full);
    wrap_lo         = cmd_addr_i & ~(wrap_bytes - ADDR_WIDTH'(1));
    aligned_lo      = cmd_addr_i[11:0] & ~size_mask[11:0];
    cross_sum       = 17'(aligned_lo) + wrap_bytes_full;
    len_ok          = (cmd_len_i == 8'd1) || (cmd_len_i == 8'd3) ||
                      (cmd_len_i == 8'd7) || (cmd_len_i == 8'd15);
    cmd_err         = (cmd_size_i > MAX_SIZE) ||
                      (cmd_burst_i == AxBURST_RESERVED) ||
                      ((cmd_burst_i == AxBURST_WRAP) &&
                       (!len_ok || ((cmd_addr_i & size_mask) != '0))) ||
                      ((cmd_burst_i == AxBURST_INCR) && (cross_sum > 17'd4096));
  end

  // Next beat address from the latched burst parameters.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    wrap_nxt  = beat_addr_o + step;
    next_addr = beat_addr_o;
    case (burst_q)
      AxBURST_INCR: next_addr = (beat_addr_o & ~(step - ADDR_WIDTH'(1))) + step;
      AxBURST_WRAP: next_addr = (wrap_nxt == wrap_hi_q) ? wrap_lo_q : wrap_nxt;
      default:      next_addr = beat_addr_o;
    endcase
  end

  // A new command can load while the previous burst retires its last beat.
  always_comb begin
    beat_hs     = beat_valid_o & beat_ready_i;
    cmd_ready_o = (state == IDLE) | (beat_hs & beat_last_o);
    accept      = cmd_valid_i & cmd_ready_o;
  end

  // Burst FSM; illegal bursts are stored as FIXED so they still emit len+1 beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      beat_addr_o  <= '0;
      beat_idx_o   <= 8'd0;
      beat_last_o  <= 1'b0;
      beat_err_o   <= 1'b0;
      len_q        <= 8'd0;
      size_q       <= 3'd0;
      burst_q      <= AxBURST_FIXED;
      wrap_lo_q    <= '0;
      wrap_hi_q    <= '0;
    end else if (accept) begin
      state        <= RUN;
      beat_valid_o <= 1'b1;
      busy_o       <= 1'b1;
      beat_addr_o  <= cmd_addr_i;
      beat_idx_o   <= 8'd0;
      beat_last_o  <= (cmd_len_i == 8'd0);
      beat_err_o   <= cmd_err;
      len_q        <= cmd_len_i;
      size_q       <= cmd_size_i;
      burst_q      <= cmd_err ? AxBURST_FIXED : cmd_burst_i;
      wrap_lo_q    <= wrap_lo;
      wrap_hi_q    <= wrap_lo + wrap_bytes;
    end else if (beat_hs) begin
      if (beat_last_o) begin
        state        <= IDLE;
        beat_valid_o <= 1'b0;
        busy_o       <= 1'b0;
      end else begin
        beat_addr_o <= next_addr;
        beat_idx_o  <= beat_idx_o + 8'd1;
        beat_last_o <= ((beat_idx_o + 8'd1) == len_q);
      end
    end
  end

endmodule
